// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback commit unit and its
// long-latency FP result queue.
package wb_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } lat_entry_t;

   // The queue uses wrapping power-of-two pointers, so only small powers of two are legal.
   function automatic bit lat_depth_legal(input int depth);
      return (depth == 2) || (depth == 4);
   endfunction
endpackage

// File: rtl/wb_lat_queue.sv
// Circular queue for out-of-band fdiv/fsqrt results.
// Supports kill-by-rd from younger pipeline FP writes, and pending-bit generation for the hazard unit.
module wb_lat_queue import wb_pkg::*; #(
   parameter int LAT_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lat_valid,
   input  logic [REG_AW-1:0] lat_rd,
   input  logic [XLEN-1:0]   lat_data,
   output logic              lat_ready,
   input  logic              kill_en,
   input  logic [REG_AW-1:0] kill_rd,
   output logic              lat_direct,
   output logic              drain_we,
   output logic [REG_AW-1:0] drain_rd,
   output logic [XLEN-1:0]   drain_data,
   output logic [XLEN-1:0]   fp_pend
);
   localparam int PTR_W = $clog2(LAT_DEPTH);
   localparam int CNT_W = $clog2(LAT_DEPTH + 1);

   if (!lat_depth_legal(LAT_DEPTH)) begin : g_bad_depth
      $error("wb_lat_queue: LAT_DEPTH must be 2 or 4");
   end

   lat_entry_t       entries_q [LAT_DEPTH];
   lat_entry_t       entries_d [LAT_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             empty, full, push, pop;
   lat_entry_t       head;

   assign empty      = (count_q == '0);
   assign full       = (count_q == CNT_W'(LAT_DEPTH));
   assign head       = entries_q[rd_ptr_q];
   assign lat_ready  = !rst && !full;
   assign lat_direct = empty && !kill_en && lat_valid;
   assign push       = lat_valid && lat_ready && !lat_direct;
   // A killed head leaves silently even while the pipeline owns the write port.
   assign pop        = !empty && (!head.valid || !kill_en);
   assign drain_we   = !empty && head.valid && !kill_en;
   assign drain_rd   = head.rd;
   assign drain_data = head.data;

   always_comb begin
      entries_d = entries_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      for (int i = 0; i < LAT_DEPTH; i++) begin
         if (kill_en && entries_q[i].valid && entries_q[i].rd == kill_rd) begin
            entries_d[i].valid = 1'b0;
         end
      end
      if (pop) begin
         entries_d[rd_ptr_q].valid = 1'b0;
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
         entries_d[wr_ptr_q].valid = !(kill_en && lat_rd == kill_rd);
         entries_d[wr_ptr_q].rd    = lat_rd;
         entries_d[wr_ptr_q].data  = lat_data;
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_comb begin
      fp_pend = '0;
      for (int i = 0; i < LAT_DEPTH; i++) begin
         if (entries_q[i].valid) fp_pend[entries_q[i].rd] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LAT_DEPTH; i++) entries_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         entries_q <= entries_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
      end
   end
endmodule

// File: rtl/wb_commit_unit.sv
// Writeback commit: integer/FP register-file write ports plus long-latency FP arbitration.
// Optional retire counter enabled by defining WB_INSTRET_EN.
module wb_commit_unit import wb_pkg::*; #(
   parameter int LAT_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [XLEN-1:0]   wb_load_data,
   input  logic [XLEN-1:0]   wb_alu_result,
   input  logic [XLEN-1:0]   wb_fp_result,
   input  logic [REG_AW-1:0] wb_rd_addr,
   input  logic              wb_wb_sel,
   input  logic              wb_fp_en,
   input  logic              wb_int_en,
   input  logic              lat_valid,
   input  logic [REG_AW-1:0] lat_rd,
   input  logic [XLEN-1:0]   lat_data,
   output logic              lat_ready,
   output logic              int_we,
   output logic [REG_AW-1:0] int_waddr,
   output logic [XLEN-1:0]   int_wdata,
   output logic              fp_we,
   output logic [REG_AW-1:0] fp_waddr,
   output logic [XLEN-1:0]   fp_wdata,
   output logic [XLEN-1:0]   fp_pend,
   output logic [63:0]       instret
);
   logic              int_we_q, int_we_d, fp_we_q, fp_we_d;
   logic [REG_AW-1:0] int_waddr_q, int_waddr_d, fp_waddr_q, fp_waddr_d;
   logic [XLEN-1:0]   int_wdata_q, int_wdata_d, fp_wdata_q, fp_wdata_d;
   logic              lat_direct, drain_we;
   logic [REG_AW-1:0] drain_rd;
   logic [XLEN-1:0]   drain_data;

   wb_lat_queue #(.LAT_DEPTH(LAT_DEPTH)) u_lat_queue (
      .clk        (clk),
      .rst        (rst),
      .lat_valid  (lat_valid),
      .lat_rd     (lat_rd),
      .lat_data   (lat_data),
      .lat_ready  (lat_ready),
      .kill_en    (wb_fp_en),
      .kill_rd    (wb_rd_addr),
      .lat_direct (lat_direct),
      .drain_we   (drain_we),
      .drain_rd   (drain_rd),
      .drain_data (drain_data),
      .fp_pend    (fp_pend)
   );

   always_comb begin
      int_we_d    = wb_int_en && (wb_rd_addr != '0);
      int_waddr_d = wb_rd_addr;
      int_wdata_d = wb_wb_sel ? wb_load_data : wb_alu_result;
      fp_we_d     = 1'b0;
      fp_waddr_d  = fp_waddr_q;
      fp_wdata_d  = fp_wdata_q;
      // The in-order pipeline is always younger than anything queued, so it wins the port.
      if (wb_fp_en) begin
         fp_we_d    = 1'b1;
         fp_waddr_d = wb_rd_addr;
         fp_wdata_d = wb_fp_result;
      end else if (drain_we) begin
         fp_we_d    = 1'b1;
         fp_waddr_d = drain_rd;
         fp_wdata_d = drain_data;
      end else if (lat_direct) begin
         fp_we_d    = 1'b1;
         fp_waddr_d = lat_rd;
         fp_wdata_d = lat_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         int_we_q    <= 1'b0;
         int_waddr_q <= '0;
         int_wdata_q <= '0;
         fp_we_q     <= 1'b0;
         fp_waddr_q  <= '0;
         fp_wdata_q  <= '0;
      end else begin
         int_we_q    <= int_we_d;
         int_waddr_q <= int_waddr_d;
         int_wdata_q <= int_wdata_d;
         fp_we_q     <= fp_we_d;
         fp_waddr_q  <= fp_waddr_d;
         fp_wdata_q  <= fp_wdata_d;
      end
   end

   assign int_we    = int_we_q;
   assign int_waddr = int_waddr_q;
   assign int_wdata = int_wdata_q;
   assign fp_we     = fp_we_q;
   assign fp_waddr  = fp_waddr_q;
   assign fp_wdata  = fp_wdata_q;

`ifdef WB_INSTRET_EN
   logic [63:0] instret_q, instret_d;

   // Long-latency completions were already counted when they issued.
   always_comb instret_d = instret_q + 64'(wb_int_en || wb_fp_en);

   always_ff @(posedge clk) begin
      if (rst) instret_q <= '0;
      else     instret_q <= instret_d;
   end

   assign instret = instret_q;
`else
   assign instret = '0;
`endif
endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_wb_commit_unit;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wb_load_data, wb_alu_result, wb_fp_result, lat_data;
   logic [4:0]  wb_rd_addr, lat_rd;
   logic        wb_wb_sel, wb_fp_en, wb_int_en, lat_valid;
   logic        lat_ready, int_we, fp_we;
   logic [4:0]  int_waddr, fp_waddr;
   logic [31:0] int_wdata, fp_wdata, fp_pend;
   logic [63:0] instret;

   always #5 clk = ~clk;

   wb_commit_unit #(.LAT_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .wb_load_data(wb_load_data), .wb_alu_result(wb_alu_result), .wb_fp_result(wb_fp_result),
      .wb_rd_addr(wb_rd_addr), .wb_wb_sel(wb_wb_sel), .wb_fp_en(wb_fp_en), .wb_int_en(wb_int_en),
      .lat_valid(lat_valid), .lat_rd(lat_rd), .lat_data(lat_data), .lat_ready(lat_ready),
      .int_we(int_we), .int_waddr(int_waddr), .int_wdata(int_wdata),
      .fp_we(fp_we), .fp_waddr(fp_waddr), .fp_wdata(fp_wdata),
      .fp_pend(fp_pend), .instret(instret)
   );

   typedef struct {
      bit        int_en, fp_en, sel, lv;
      bit [4:0]  rd, lrd;
      bit [31:0] load, alu, fpres, ldata;
   } stim_t;

   typedef struct {
      stim_t     s;
      bit        e_int_we;
      bit [4:0]  e_iaddr;
      bit [31:0] e_idata;
      bit        e_fp_we;
      bit [4:0]  e_faddr;
      bit [31:0] e_fdata;
   } vec_t;

   typedef struct {
      bit        valid;
      bit [4:0]  rd;
      bit [31:0] data;
   } ment_t;

   int          n_vec = 0;
   int          n_bad = 0;
   ment_t       mq[$];
   bit [63:0]   m_instret;
   bit          e_int_we, e_fp_we;
   bit [4:0]    e_iaddr, e_faddr;
   bit [31:0]   e_idata, e_fdata;
   vec_t        tbl[8];

   function automatic stim_t mk(bit int_en, bit fp_en, bit sel, bit [4:0] rd, bit [31:0] load,
                                bit [31:0] alu, bit [31:0] fpres, bit lv, bit [4:0] lrd,
                                bit [31:0] ldata);
      stim_t s;
      s.int_en = int_en; s.fp_en = fp_en; s.sel = sel; s.rd = rd; s.load = load;
      s.alu = alu; s.fpres = fpres; s.lv = lv; s.lrd = lrd; s.ldata = ldata;
      return s;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input stim_t s);
      wb_int_en = s.int_en; wb_fp_en = s.fp_en; wb_wb_sel = s.sel; wb_rd_addr = s.rd;
      wb_load_data = s.load; wb_alu_result = s.alu; wb_fp_result = s.fpres;
      lat_valid = s.lv; lat_rd = s.lrd; lat_data = s.ldata;
   endtask

   function automatic bit [63:0] exp_instret();
`ifdef WB_INSTRET_EN
      return m_instret;
`else
      return 64'd0;
`endif
   endfunction

   // One clock: check queue-state outputs, advance the model, check registered outputs.
   task automatic step();
      bit        exp_ready, pop, accept, empty;
      bit [31:0] pend;
      #1;
      exp_ready = !rst && (mq.size() < DEPTH);
      pend = '0;
      foreach (mq[i]) if (mq[i].valid) pend[mq[i].rd] = 1'b1;
      chk("lat_ready", 64'(lat_ready), 64'(exp_ready));
      chk("fp_pend", 64'(fp_pend), 64'(pend));
      if (rst) begin
         mq.delete();
         m_instret = 0;
         e_int_we = 0; e_iaddr = 0; e_idata = 0; e_fp_we = 0;
      end else begin
         empty    = (mq.size() == 0);
         e_int_we = wb_int_en && (wb_rd_addr != 0);
         e_iaddr  = wb_rd_addr;
         e_idata  = wb_wb_sel ? wb_load_data : wb_alu_result;
         e_fp_we  = 1'b1;
         if (wb_fp_en) begin
            e_faddr = wb_rd_addr; e_fdata = wb_fp_result;
         end else if (!empty && mq[0].valid) begin
            e_faddr = mq[0].rd; e_fdata = mq[0].data;
         end else if (empty && lat_valid) begin
            e_faddr = lat_rd; e_fdata = lat_data;
         end else begin
            e_fp_we = 1'b0;
         end
         pop    = !empty && (!mq[0].valid || !wb_fp_en);
         accept = lat_valid && (mq.size() < DEPTH) && !(empty && !wb_fp_en);
         if (wb_fp_en) foreach (mq[i]) if (mq[i].rd == wb_rd_addr) mq[i].valid = 1'b0;
         if (pop) void'(mq.pop_front());
         if (accept)
            mq.push_back('{valid: !(wb_fp_en && lat_rd == wb_rd_addr), rd: lat_rd, data: lat_data});
         if (wb_int_en || wb_fp_en) m_instret++;
      end
      @(posedge clk);
      #1;
      chk("int_we", 64'(int_we), 64'(e_int_we));
      chk("int_waddr", 64'(int_waddr), 64'(e_iaddr));
      chk("int_wdata", 64'(int_wdata), 64'(e_idata));
      chk("fp_we", 64'(fp_we), 64'(e_fp_we));
      if (e_fp_we) begin
         chk("fp_waddr", 64'(fp_waddr), 64'(e_faddr));
         chk("fp_wdata", 64'(fp_wdata), 64'(e_fdata));
      end
      chk("instret", instret, exp_instret());
   endtask

   task automatic run(input stim_t s);
      drive(s);
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst = 1'b0;
   endtask

   stim_t idle;

   initial begin
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      drive(idle);

      // int_en fp_en sel rd load alu fpres lv lrd ldata
      tbl[0] = '{mk(1, 0, 1, 5, 32'hDEADBEEF, 32'h11111111, 0, 0, 0, 0), 1, 5, 32'hDEADBEEF, 0, 0, 0};
      tbl[1] = '{mk(1, 0, 1, 0, 32'h12345678, 32'h22222222, 0, 0, 0, 0), 0, 0, 32'h12345678, 0, 0, 0};
      tbl[2] = '{mk(1, 0, 0, 31, 32'h00005555, 32'hCAFEF00D, 0, 0, 0, 0), 1, 31, 32'hCAFEF00D, 0, 0, 0};
      tbl[3] = '{mk(0, 0, 0, 12, 0, 32'hA5A5A5A5, 0, 0, 0, 0), 0, 12, 32'hA5A5A5A5, 0, 0, 0};
      tbl[4] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h3F800000), 0, 0, 0, 1, 3, 32'h3F800000};
      tbl[5] = '{mk(0, 1, 0, 0, 0, 0, 32'h40490FDB, 0, 0, 0), 0, 0, 0, 1, 0, 32'h40490FDB};
      tbl[6] = '{mk(1, 1, 0, 17, 0, 32'h77, 32'hBF800000, 0, 0, 0), 1, 17, 32'h77, 1, 17, 32'hBF800000};
      tbl[7] = '{idle, 0, 0, 0, 0, 0, 0};

      @(negedge clk);
      do_reset();
      chk("reset int_we", 64'(int_we), 64'd0);
      chk("reset fp_we", 64'(fp_we), 64'd0);
      chk("reset fp_waddr", 64'(fp_waddr), 64'd0);
      chk("reset fp_wdata", 64'(fp_wdata), 64'd0);

      foreach (tbl[i]) begin
         run(tbl[i].s);
         chk($sformatf("tbl%0d int_we", i), 64'(int_we), 64'(tbl[i].e_int_we));
         chk($sformatf("tbl%0d int_waddr", i), 64'(int_waddr), 64'(tbl[i].e_iaddr));
         chk($sformatf("tbl%0d int_wdata", i), 64'(int_wdata), 64'(tbl[i].e_idata));
         chk($sformatf("tbl%0d fp_we", i), 64'(fp_we), 64'(tbl[i].e_fp_we));
         if (tbl[i].e_fp_we) begin
            chk($sformatf("tbl%0d fp_waddr", i), 64'(fp_waddr), 64'(tbl[i].e_faddr));
            chk($sformatf("tbl%0d fp_wdata", i), 64'(fp_wdata), 64'(tbl[i].e_fdata));
         end
         chk($sformatf("tbl%0d fp_pend", i), 64'(fp_pend), 64'd0);
      end

      // Collision and back-pressure: pipeline holds the port while two results queue up.
      run(mk(0, 1, 0, 7, 0, 0, 32'hF0, 1, 1, 32'h100));
      run(mk(0, 1, 0, 7, 0, 0, 32'hF0, 1, 2, 32'h200));
      chk("coll lat_ready", 64'(lat_ready), 64'd0);
      chk("coll fp_pend", 64'(fp_pend), 64'h6);
      run(mk(0, 1, 0, 7, 0, 0, 32'hF0, 0, 0, 0));
      run(mk(0, 1, 0, 7, 0, 0, 32'hF0, 0, 0, 0));
      chk("coll hold ready", 64'(lat_ready), 64'd0);
      chk("coll hold pend", 64'(fp_pend), 64'h6);
      run(idle);
      chk("drain1 fp_we", 64'(fp_we), 64'd1);
      chk("drain1 waddr", 64'(fp_waddr), 64'd1);
      chk("drain1 wdata", 64'(fp_wdata), 64'h100);
      run(idle);
      chk("drain2 fp_we", 64'(fp_we), 64'd1);
      chk("drain2 waddr", 64'(fp_waddr), 64'd2);
      chk("drain2 wdata", 64'(fp_wdata), 64'h200);
      run(idle);
      chk("drained fp_we", 64'(fp_we), 64'd0);

      // WAW kill: younger pipeline write to f9 invalidates the queued f9 result.
      run(mk(0, 1, 0, 7, 0, 0, 32'h70, 1, 9, 32'hAAAA));
      chk("waw pend set", 64'(fp_pend), 64'h200);
      run(mk(0, 1, 0, 9, 0, 0, 32'h1, 0, 0, 0));
      chk("waw fp_waddr", 64'(fp_waddr), 64'd9);
      chk("waw fp_wdata", 64'(fp_wdata), 64'h1);
      chk("waw pend clr", 64'(fp_pend), 64'd0);
      run(idle);
      chk("waw silent pop", 64'(fp_we), 64'd0);
      chk("waw ready", 64'(lat_ready), 64'd1);

      // Reset while the queue is full.
      run(mk(1, 1, 0, 7, 0, 5, 32'h70, 1, 4, 32'h44));
      run(mk(1, 1, 0, 7, 0, 5, 32'h70, 1, 5, 32'h55));
      chk("full ready", 64'(lat_ready), 64'd0);
      rst = 1'b1;
      drive(mk(1, 1, 0, 3, 0, 0, 0, 1, 6, 32'h66));
      #1;
      chk("rst ready low", 64'(lat_ready), 64'd0);
      step();
      rst = 1'b0;
      drive(idle);
      #1;
      chk("post-rst ready", 64'(lat_ready), 64'd1);
      chk("post-rst pend", 64'(fp_pend), 64'd0);
      chk("post-rst instret", instret, 64'd0);
      chk("post-rst int_we", 64'(int_we), 64'd0);
      chk("post-rst fp_we", 64'(fp_we), 64'd0);

      // Retire counter: 10 alternating integer/FP retirements.
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) run(mk(1, 0, 0, 4, 0, 32'(i), 0, 0, 0, 0));
         else            run(mk(0, 1, 0, 4, 0, 0, 32'(i), 0, 0, 0));
      end
`ifdef WB_INSTRET_EN
      chk("instret10", instret, 64'd10);
`else
      chk("instret10", instret, 64'd0);
`endif

      // Randomized traffic with a narrow rd range to provoke kills and collisions.
      for (int n = 0; n < 3000; n++) begin
         stim_t s;
         s.int_en = ($urandom_range(0, 1) == 1);
         s.fp_en  = ($urandom_range(0, 2) == 0);
         s.sel    = ($urandom_range(0, 1) == 1);
         s.rd     = 5'($urandom_range(0, 7));
         s.load   = $urandom;
         s.alu    = $urandom;
         s.fpres  = $urandom;
         s.lv     = ($urandom_range(0, 1) == 1);
         s.lrd    = 5'($urandom_range(0, 7));
         s.ldata  = $urandom;
         rst = ($urandom_range(0, 63) == 0);
         run(s);
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
